// File: rtl/qr_sram_rd_arb_if.sv
// Read-port bundle between the two pixel-SRAM requesters, the arbiter and the SRAM.
// Handshake: req_x is "valid", gnt_x is "ready"; an address transfers on req_x && gnt_x,
// and the requester holds req_x/addr_x stable until it sees gnt_x.
interface qr_sram_rd_arb_if #(
    parameter int AW = 8,
    parameter int DW = 4
);
    logic          req0;
    logic          lock0;
    logic [AW-1:0] addr0;
    logic          gnt0;
    logic          rvalid0;
    logic [DW-1:0] rdata0;

    logic          req1;
    logic          lock1;
    logic [AW-1:0] addr1;
    logic          gnt1;
    logic          rvalid1;
    logic [DW-1:0] rdata1;

    logic          sram_ren;
    logic [AW-1:0] sram_raddr;
    logic [DW-1:0] sram_rdata;
    logic          busy;

    modport master (
        output req0, lock0, addr0, req1, lock1, addr1, sram_rdata,
        input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
        input  sram_ren, sram_raddr, busy
    );

    modport slave (
        input  req0, lock0, addr0, req1, lock1, addr1, sram_rdata,
        output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
        output sram_ren, sram_raddr, busy
    );
endinterface

// File: rtl/qr_sram_rd_arb.sv
// Round-robin read-port arbiter for the pixel SRAM with burst lock and a bounded hold,
// steering the one-cycle-latency read data back to the requester that issued the address.
module qr_sram_rd_arb #(
    parameter int MAX_HOLD = 8,
    parameter int AW       = 8,
    parameter int DW       = 4
) (
    input  logic             clk,
    input  logic             rst,
    qr_sram_rd_arb_if.slave  bus,
    output logic [1:0]       dbg_state,
    output logic [3:0]       dbg_hold_cnt
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

    state_t        state;
    logic          last_owner;
    logic [3:0]    hold_cnt;
    logic          rvalid0_q;
    logic          rvalid1_q;
    logic [AW-1:0] raddr_q;

    logic          gnt0_c;
    logic          gnt1_c;
    logic          hold_ok;

    // Lock rules first, then round-robin on contention, then a lone request.
    always_comb begin
        gnt0_c  = 1'b0;
        gnt1_c  = 1'b0;
        hold_ok = (hold_cnt < MAX_HOLD_C);
        if (rst) begin
            gnt0_c = 1'b0;
            gnt1_c = 1'b0;
        end else if (state == OWN0 && bus.req0 && bus.lock0 && (!bus.req1 || hold_ok)) begin
            gnt0_c = 1'b1;
        end else if (state == OWN1 && bus.req1 && bus.lock1 && (!bus.req0 || hold_ok)) begin
            gnt1_c = 1'b1;
        end else if (bus.req0 && bus.req1) begin
            if (last_owner) gnt0_c = 1'b1;
            else            gnt1_c = 1'b1;
        end else if (bus.req0) begin
            gnt0_c = 1'b1;
        end else if (bus.req1) begin
            gnt1_c = 1'b1;
        end
    end

    assign bus.gnt0       = gnt0_c;
    assign bus.gnt1       = gnt1_c;
    assign bus.sram_ren   = gnt0_c | gnt1_c;
    assign bus.sram_raddr = gnt0_c ? bus.addr0 : (gnt1_c ? bus.addr1 : raddr_q);
    assign bus.rvalid0    = rvalid0_q;
    assign bus.rvalid1    = rvalid1_q;
    assign bus.rdata0     = rvalid0_q ? bus.sram_rdata : '0;
    assign bus.rdata1     = rvalid1_q ? bus.sram_rdata : '0;
    assign bus.busy       = (state != IDLE);
    assign dbg_state      = state;
    assign dbg_hold_cnt   = hold_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            hold_cnt   <= 4'd0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            raddr_q    <= '0;
        end else begin
            rvalid0_q <= gnt0_c;
            rvalid1_q <= gnt1_c;
            if (gnt0_c) begin
                state      <= OWN0;
                last_owner <= 1'b0;
                raddr_q    <= bus.addr0;
                if (state == OWN0)
                    hold_cnt <= (hold_cnt >= MAX_HOLD_C) ? MAX_HOLD_C : hold_cnt + 4'd1;
                else
                    hold_cnt <= 4'd1;
            end else if (gnt1_c) begin
                state      <= OWN1;
                last_owner <= 1'b1;
                raddr_q    <= bus.addr1;
                if (state == OWN1)
                    hold_cnt <= (hold_cnt >= MAX_HOLD_C) ? MAX_HOLD_C : hold_cnt + 4'd1;
                else
                    hold_cnt <= 4'd1;
            end else begin
                state    <= IDLE;
                hold_cnt <= 4'd0;
            end
        end
    end
endmodule
